// File: rtl/lsu_mem_if_if.sv
// Signal bundle for the lsu_mem_if stage: request/response handshakes plus the word-wide data memory bus.
// The master side is the environment: pipeline plus data memory.
interface lsu_mem_if_if #(
    parameter int width = 32
);
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [2:0]       req_funct3;
    logic [width-1:0] req_addr;
    logic [width-1:0] req_wdata;
    logic             resp_valid;
    logic             resp_ready;
    logic [width-1:0] resp_rdata;
    logic             resp_err;
    logic [width-1:0] mem_addr;
    logic             mem_read;
    logic             mem_write;
    logic [width-1:0] mem_wdata;
    logic [width-1:0] mem_rdata;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_read, mem_write, mem_wdata
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_read, mem_write, mem_wdata
    );
endinterface

// File: rtl/lsu_mem_if.sv
// Load/store stage between MEM and a word-wide data memory without byte enables:
// sub-word loads are extracted and extended, sub-word stores go through read-modify-write.
module lsu_mem_if #(
    parameter int width = 32
) (
    input logic          clk,
    input logic          rst_n,
    lsu_mem_if_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_REQ   = 3'd1,
        RD_WAIT  = 3'd2,
        RMW_RD   = 3'd3,
        RMW_WAIT = 3'd4,
        WR       = 3'd5,
        RESP     = 3'd6
    } state_t;

    state_t           state_r;
    logic [width-1:0] addr_r;
    logic [width-1:0] wdata_r;
    logic [width-1:0] mem_wdata_r;
    logic [width-1:0] resp_rdata_r;
    logic [2:0]       funct3_r;
    logic             resp_err_r;
    logic             req_ready_r;
    logic             accept_s;
    logic             req_err_s;

    // Illegal funct3 for the direction, or address not aligned to the access size.
    function automatic logic access_err(input logic we, input logic [2:0] f3, input logic [1:0] a);
        logic err;
        case (f3)
            3'b000:  err = 1'b0;
            3'b001:  err = a[0];
            3'b010:  err = (a != 2'b00);
            3'b100:  err = we;
            3'b101:  err = we | a[0];
            default: err = 1'b1;
        endcase
        return err;
    endfunction

    function automatic logic [width-1:0] load_extract(input logic [2:0] f3, input logic [1:0] a,
                                                      input logic [width-1:0] rdata);
        logic [width-1:0] sh;
        logic [width-1:0] res;
        sh = rdata >> {a, 3'b000};
        case (f3)
            3'b000:  res = {{(width-8){sh[7]}}, sh[7:0]};
            3'b001:  res = {{(width-16){sh[15]}}, sh[15:0]};
            3'b010:  res = rdata;
            3'b100:  res = {{(width-8){1'b0}}, sh[7:0]};
            3'b101:  res = {{(width-16){1'b0}}, sh[15:0]};
            default: res = {width{1'b0}};
        endcase
        return res;
    endfunction

    // Replace the addressed byte/halfword lane of the old word with the low bits of wdata.
    function automatic logic [width-1:0] store_merge(input logic [2:0] f3, input logic [1:0] a,
                                                     input logic [width-1:0] rdata,
                                                     input logic [width-1:0] wdata);
        logic [width-1:0] mask;
        logic [width-1:0] ins;
        case (f3)
            3'b000:  mask = {{(width-8){1'b0}}, 8'hFF};
            3'b001:  mask = {{(width-16){1'b0}}, 16'hFFFF};
            default: mask = {width{1'b1}};
        endcase
        mask = mask << {a, 3'b000};
        ins  = (wdata << {a, 3'b000}) & mask;
        return (rdata & ~mask) | ins;
    endfunction

    assign accept_s  = bus.req_valid & req_ready_r;
    assign req_err_s = access_err(bus.req_we, bus.req_funct3, bus.req_addr[1:0]);

    // Transaction FSM; req_ready is registered so it stays low while reset is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            addr_r       <= {width{1'b0}};
            wdata_r      <= {width{1'b0}};
            mem_wdata_r  <= {width{1'b0}};
            resp_rdata_r <= {width{1'b0}};
            funct3_r     <= 3'b000;
            resp_err_r   <= 1'b0;
            req_ready_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        addr_r       <= bus.req_addr;
                        wdata_r      <= bus.req_wdata;
                        mem_wdata_r  <= bus.req_wdata;
                        funct3_r     <= bus.req_funct3;
                        resp_rdata_r <= {width{1'b0}};
                        resp_err_r   <= req_err_s;
                        req_ready_r  <= 1'b0;
                        if (req_err_s) begin
                            state_r <= RESP;
                        end else if (!bus.req_we) begin
                            state_r <= RD_REQ;
                        end else if (bus.req_funct3 == 3'b010) begin
                            state_r <= WR;
                        end else begin
                            state_r <= RMW_RD;
                        end
                    end else begin
                        req_ready_r <= 1'b1;
                    end
                end
                RD_REQ:   state_r <= RD_WAIT;
                RD_WAIT: begin
                    resp_rdata_r <= load_extract(funct3_r, addr_r[1:0], bus.mem_rdata);
                    state_r      <= RESP;
                end
                RMW_RD:   state_r <= RMW_WAIT;
                RMW_WAIT: begin
                    mem_wdata_r <= store_merge(funct3_r, addr_r[1:0], bus.mem_rdata, wdata_r);
                    state_r     <= WR;
                end
                WR:       state_r <= RESP;
                RESP: begin
                    if (bus.resp_ready) begin
                        state_r     <= IDLE;
                        req_ready_r <= 1'b1;
                    end else begin
                        state_r <= RESP;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    req_ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready  = req_ready_r;
    assign bus.resp_valid = (state_r == RESP);
    assign bus.resp_rdata = resp_rdata_r;
    assign bus.resp_err   = resp_err_r;
    assign bus.mem_addr   = {addr_r[width-1:2], 2'b00};
    assign bus.mem_read   = (state_r == RD_REQ) || (state_r == RMW_RD);
    assign bus.mem_write  = (state_r == WR);
    assign bus.mem_wdata  = mem_wdata_r;

endmodule

// File: tb/tb_lsu_mem_if.sv
// Bench for lsu_mem_if: directed cases plus random traffic checked against a byte-addressed memory model.
module tb_lsu_mem_if;
    localparam int W = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lsu_mem_if_if #(.width(W)) bus ();
    lsu_mem_if #(.width(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_chk  = 0;
    int n_pass = 0;

    // Word-wide data memory seen by the DUT, 16 words.
    logic [31:0] mem [0:15];
    logic        pre_we  = 1'b0;
    logic [3:0]  pre_idx = 4'd0;
    logic [31:0] pre_val = 32'd0;
    int          rd_cnt  = 0;
    int          wr_cnt  = 0;
    logic [31:0] last_rd_addr = 32'd0;
    logic [31:0] last_wr_addr = 32'd0;

    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_idx] <= pre_val;
        end else if (bus.mem_write) begin
            mem[bus.mem_addr[5:2]] <= bus.mem_wdata;
            wr_cnt       <= wr_cnt + 1;
            last_wr_addr <= bus.mem_addr;
        end
        if (bus.mem_read) begin
            bus.mem_rdata <= mem[bus.mem_addr[5:2]];
            rd_cnt        <= rd_cnt + 1;
            last_rd_addr  <= bus.mem_addr;
        end
    end

    // Reference model: plain byte array with RV32 load/store rules.
    logic [7:0] ref_b [0:63];

    function automatic logic ref_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
        int size;
        if (we ? (f3 > 3'd2) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
        size = 1 << f3[1:0];
        return (int'(a) % size) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] v;
        int n;
        n = 1 << f3[1:0];
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_b[int'(a) + i]) << (8 * i));
        if (!f3[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wdata);
        int n;
        n = 1 << f3[1:0];
        for (int i = 0; i < n; i++) ref_b[int'(a) + i] = wdata[8*i +: 8];
    endtask

    function automatic logic [31:0] ref_word(input logic [3:0] idx);
        int b;
        b = 4 * int'(idx);
        return {ref_b[b+3], ref_b[b+2], ref_b[b+1], ref_b[b]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // One complete request/response; hold = cycles resp_ready stays low after resp_valid.
    task automatic do_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input int hold, output logic [31:0] got);
        logic        exp_err;
        logic [31:0] exp_rdata;
        int exp_lat, exp_rd, exp_wr, rd0, wr0, lat, waitc;
        exp_err   = ref_err(we, f3, addr);
        exp_rdata = (exp_err || we) ? 32'd0 : ref_load(f3, addr);
        if (exp_err) begin
            exp_lat = 1; exp_rd = 0; exp_wr = 0;
        end else if (!we) begin
            exp_lat = 3; exp_rd = 1; exp_wr = 0;
        end else if (f3 == 3'd2) begin
            exp_lat = 2; exp_rd = 0; exp_wr = 1;
        end else begin
            exp_lat = 4; exp_rd = 1; exp_wr = 1;
        end
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        waitc = 0;
        while (!bus.req_ready && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        chk("accept", 32'(bus.req_ready), 32'd1);
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        got = bus.resp_rdata;
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("resp_err", 32'(bus.resp_err), 32'(exp_err));
        chk("resp_rdata", bus.resp_rdata, exp_rdata);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(bus.resp_valid), 32'd1);
            chk("hold_rdata", bus.resp_rdata, exp_rdata);
            chk("hold_ready", 32'(bus.req_ready), 32'd0);
        end
        chk("rd_cnt", 32'(rd_cnt - rd0), 32'(exp_rd));
        chk("wr_cnt", 32'(wr_cnt - wr0), 32'(exp_wr));
        if (exp_rd != 0) chk("rd_addr", last_rd_addr, {addr[31:2], 2'b00});
        if (exp_wr != 0) chk("wr_addr", last_wr_addr, {addr[31:2], 2'b00});
        bus.resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.resp_ready = 1'b0;
        chk("resp_drop", 32'(bus.resp_valid), 32'd0);
        chk("ready_back", 32'(bus.req_ready), 32'd1);
        if (we && !exp_err) ref_store(f3, addr, wdata);
        chk("mem_word", mem[addr[5:2]], ref_word(addr[5:2]));
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] v;
        int wr0, waitc;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        bus.resp_ready = 1'b0;

        // Preload memory and model while reset is held.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            v = (i == 4) ? 32'h80FF_7F55 : $urandom;
            pre_we  = 1'b1;
            pre_idx = 4'(i);
            pre_val = v;
            for (int k = 0; k < 4; k++) ref_b[4*i + k] = v[8*k +: 8];
        end
        @(negedge clk);
        pre_we = 1'b0;
        #1;
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_mem_read", 32'(bus.mem_read), 32'd0);
        chk("rst_mem_write", 32'(bus.mem_write), 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
        chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Sub-word loads from 0x80FF7F55 at 0x10.
        do_txn(1'b0, 3'd0, 32'h11, 32'd0, 0, got); chk("lb_11", got, 32'h0000_007F);
        do_txn(1'b0, 3'd0, 32'h12, 32'd0, 0, got); chk("lb_12", got, 32'hFFFF_FFFF);
        do_txn(1'b0, 3'd4, 32'h13, 32'd0, 0, got); chk("lbu_13", got, 32'h0000_0080);
        do_txn(1'b0, 3'd1, 32'h12, 32'd0, 0, got); chk("lh_12", got, 32'hFFFF_80FF);
        do_txn(1'b0, 3'd5, 32'h10, 32'd0, 0, got); chk("lhu_10", got, 32'h0000_7F55);

        // Read-modify-write stores.
        do_txn(1'b1, 3'd0, 32'h11, 32'h0000_00AB, 0, got);
        chk("sb_word", mem[4], 32'h80FF_AB55);
        do_txn(1'b1, 3'd1, 32'h12, 32'h0000_1234, 0, got);
        chk("sh_word", mem[4], 32'h1234_AB55);

        // Full-word store then load back.
        do_txn(1'b1, 3'd2, 32'h08, 32'hDEAD_BEEF, 0, got);
        do_txn(1'b0, 3'd2, 32'h08, 32'd0, 0, got); chk("lw_08", got, 32'hDEAD_BEEF);

        // Errors: misaligned word/half, illegal funct3.
        do_txn(1'b0, 3'd2, 32'h06, 32'd0, 0, got);
        do_txn(1'b0, 3'd1, 32'h05, 32'd0, 0, got);
        do_txn(1'b0, 3'd3, 32'h10, 32'd0, 0, got);
        do_txn(1'b1, 3'd4, 32'h10, 32'h5555_5555, 0, got);

        // Back-pressure on the response.
        do_txn(1'b0, 3'd2, 32'h10, 32'd0, 3, got); chk("lw_hold", got, 32'h1234_AB55);

        // Reset pulsed while an SB sits in RMW_WAIT.
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'h11;
        bus.req_wdata  = 32'h0000_00CD;
        waitc = 0;
        while (!bus.req_ready && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        chk("abort_accept", 32'(bus.req_ready), 32'd1);
        wr0 = wr_cnt;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_mem_write", 32'(bus.mem_write), 32'd0);
        chk("abort_mem_read", 32'(bus.mem_read), 32'd0);
        chk("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("abort_req_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("abort_wr_cnt", 32'(wr_cnt - wr0), 32'd0);
        chk("abort_mem_word", mem[4], 32'h1234_AB55);
        rst_n = 1'b1;
        do_txn(1'b0, 3'd2, 32'h10, 32'd0, 0, got); chk("lw_after_abort", got, 32'h1234_AB55);

        // Random traffic against the model.
        for (int t = 0; t < 150; t++) begin
            do_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 32'($urandom_range(0, 63)),
                   $urandom, int'($urandom_range(0, 2)), got);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
